pll_phase_ctrl: RTL

PLL_PHASE_CTRL -- requirements
Module: pll_phase_ctrl

---
 rtl/pll_phase_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/pll_phase_ctrl.sv
// Dynamic phase-shift sequencer for a PLL PHASESEL/PHASEDIR/PHASESTEP port.
// Optional per-output phase position tracking is enabled by defining PLL_PHASE_POS_EN.
module pll_phase_ctrl #(
  parameter int STEP_HIGH = 4,
  parameter int STEP_GAP  = 8,
  parameter int SETUP     = 2,
  parameter int SETTLE    = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_sel,
  input  logic       req_dir,
  input  logic [7:0] req_count,
  output logic [1:0] phasesel,
  output logic       phasedir,
  output logic       phasestep,
  output logic       busy,
  output logic       done
`ifdef PLL_PHASE_POS_EN
  ,
  output logic [31:0] phase_pos
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STEP_HI,
    ST_STEP_LO,
    ST_SETTLE,
    ST_DONE
  } state_t;

  // SETUP spends one extra cycle so the select lines are stable for SETUP full cycles
  // after the acceptance edge that loads them.
  localparam logic [8:0] C_SETUP_LAST  = 9'(SETUP);
  localparam logic [8:0] C_HI_LAST     = 9'(STEP_HIGH - 1);
  localparam logic [8:0] C_GAP_LAST    = 9'(STEP_GAP - 1);
  localparam logic [8:0] C_SETTLE_LAST = 9'(SETTLE - 1);

  state_t     r_state;
  logic [8:0] r_cnt;
  logic [7:0] r_rem;
  logic [1:0] r_sel;
  logic       r_dir;
  logic       r_step;
  logic       r_busy;
  logic       r_done;
  logic       r_req_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_rem       <= '0;
      r_sel       <= '0;
      r_dir       <= 1'b0;
      r_step      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_req_ready <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_valid && r_req_ready) begin
            r_state     <= ST_SETUP;
            r_sel       <= req_sel;
            r_dir       <= req_dir;
            r_rem       <= req_count;
            r_cnt       <= '0;
            r_busy      <= 1'b1;
            r_req_ready <= 1'b0;
          end else begin
            r_req_ready <= 1'b1;
          end
        end
        ST_SETUP: begin
          if (r_cnt == C_SETUP_LAST) begin
            r_cnt <= '0;
            if (r_rem != 8'd0) begin
              r_state <= ST_STEP_HI;
              r_step  <= 1'b1;
            end else begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 9'd1;
          end
        end
        ST_STEP_HI: begin
          if (r_cnt == C_HI_LAST) begin
            r_cnt   <= '0;
            r_rem   <= r_rem - 8'd1;
            r_state <= ST_STEP_LO;
            r_step  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 9'd1;
          end
        end
        ST_STEP_LO: begin
          if (r_cnt == C_GAP_LAST) begin
            r_cnt <= '0;
            if (r_rem != 8'd0) begin
              r_state <= ST_STEP_HI;
              r_step  <= 1'b1;
            end else begin
              r_state <= ST_SETTLE;
            end
          end else begin
            r_cnt <= r_cnt + 9'd1;
          end
        end
        ST_SETTLE: begin
          if (r_cnt == C_SETTLE_LAST) begin
            r_cnt   <= '0;
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 9'd1;
          end
        end
        ST_DONE: begin
          r_state     <= ST_IDLE;
          r_busy      <= 1'b0;
          r_req_ready <= 1'b1;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_cnt       <= '0;
          r_step      <= 1'b0;
          r_busy      <= 1'b0;
          r_req_ready <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign phasesel  = r_sel;
  assign phasedir  = r_dir;
  assign phasestep = r_step;
  assign busy      = r_busy;
  assign done      = r_done;

`ifdef PLL_PHASE_POS_EN
  logic r_step_d;
  logic w_step_rise;

  always_ff @(posedge clk) begin
    if (!reset_n) r_step_d <= 1'b0;
    else          r_step_d <= r_step;
  end

  assign w_step_rise = r_step & ~r_step_d;

  // Fields are two's-complement step counts that wrap modulo 256.
  for (genvar gi = 0; gi < 4; gi++) begin : g_pos
    logic [7:0] r_pos;
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        r_pos <= '0;
      end else if (w_step_rise && (r_sel == 2'(gi))) begin
        r_pos <= r_dir ? (r_pos + 8'd1) : (r_pos - 8'd1);
      end
    end
    assign phase_pos[8*gi +: 8] = r_pos;
  end
`endif

endmodule
